// File: rtl/quad_osc_if.sv
// Bus bundle for the quadrature oscillator: strobe and coefficients in,
// sample and status out, plus the FSM state for observation.
//
// Handshake: sample_en is a 1-cycle request with no ready/backpressure.
// It is accepted only when busy is low. A request made while busy is dropped
// and sets the sticky overrun flag. out_valid is a 1-cycle pulse marking the
// cycle in which sample first holds the new value. There is no consumer ready.
interface quad_osc_if #(parameter int WL = 16);
  logic                 sample_en;
  logic [7:0]           freq;
  logic signed [WL-1:0] cosW;
  logic signed [WL-1:0] sinW;
  logic signed [WL-1:0] sample;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;
  logic [3:0]           state_dbg;

  modport master (
    output sample_en, freq, cosW, sinW,
    input  sample, out_valid, busy, overrun, state_dbg
  );

  modport slave (
    input  sample_en, freq, cosW, sinW,
    output sample, out_valid, busy, overrun, state_dbg
  );
endinterface

// File: rtl/quad_osc.sv
// Recursive quadrature sine oscillator. Each accepted strobe rotates (x,y)
// by W and applies a first-order gain correction toward radius 0.5. The
// sample is then 2*x. One multiplier is time-shared over eight FSM states.
module quad_osc #(
  parameter int WL = 16
) (
  input logic        clk,
  input logic        rst,
  quad_osc_if.slave  bus
);
  localparam int AW = 2*WL + 3;
  localparam logic signed [AW-1:0] RND  = AW'(2**(WL-2));
  localparam logic signed [AW-1:0] G0   = AW'(3*2**(WL-2));
  localparam logic signed [AW-1:0] SMAX = AW'(2**(WL-1) - 1);
  localparam logic signed [AW-1:0] SMIN = -AW'(2**(WL-1));
  localparam logic signed [WL-1:0] SEED = WL'(2**(WL-2));

  typedef enum logic [3:0] {
    IDLE = 4'd0, RX1 = 4'd1, RX2 = 4'd2, RY1 = 4'd3, RY2 = 4'd4,
    MX   = 4'd5, MY  = 4'd6, NX  = 4'd7, NY  = 4'd8
  } state_t;

  state_t state, state_nxt;

  logic signed [WL-1:0] x, y, xr, yr, sample_q;
  logic        [WL:0]   m;
  logic [7:0]           freq_q;
  logic                 out_valid_q, overrun_q;
  logic signed [AW-1:0] acc, op_a, op_b, prod, acc_sum, rnd, g;
  logic                 fresh, sub;

  function automatic logic signed [WL-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SMAX)      sat = SMAX[WL-1:0];
    else if (v < SMIN) sat = SMIN[WL-1:0];
    else               sat = v[WL-1:0];
  endfunction

  // Gain from the squared radius: 1.5 - 2*r^2, pulling the radius to 0.5.
  assign g = G0 - ($signed(AW'(m)) <<< 1);

  // State register; reset aborts any computation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus multiplier operand selection for the current step.
  always_comb begin
    state_nxt = state;
    op_a      = '0;
    op_b      = '0;
    fresh     = 1'b1;
    sub       = 1'b0;
    case (state)
      IDLE: if (bus.sample_en) state_nxt = RX1;
      RX1:  begin state_nxt = RX2; op_a = AW'(bus.cosW); op_b = AW'(x); end
      RX2:  begin state_nxt = RY1; op_a = AW'(bus.sinW); op_b = AW'(y);
                  fresh = 1'b0; sub = 1'b1; end
      RY1:  begin state_nxt = RY2; op_a = AW'(bus.sinW); op_b = AW'(x); end
      RY2:  begin state_nxt = MX;  op_a = AW'(bus.cosW); op_b = AW'(y);
                  fresh = 1'b0; end
      MX:   begin state_nxt = MY;  op_a = AW'(xr); op_b = AW'(xr); end
      MY:   begin state_nxt = NX;  op_a = AW'(yr); op_b = AW'(yr);
                  fresh = 1'b0; end
      NX:   begin state_nxt = NY;  op_a = g; op_b = AW'(xr); end
      NY:   begin state_nxt = IDLE; op_a = g; op_b = AW'(yr); end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared multiply-accumulate and round-half-up back to the sample scale.
  always_comb begin
    prod    = op_a * op_b;
    acc_sum = (fresh ? '0 : acc) + (sub ? -prod : prod);
    rnd     = (acc_sum + RND) >>> (WL-1);
  end

  // Datapath registers, frequency capture and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= SEED;
      y           <= '0;
      xr          <= '0;
      yr          <= '0;
      m           <= '0;
      acc         <= '0;
      freq_q      <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= (state == NY);
      if (state != IDLE) acc <= acc_sum;
      if (state != IDLE && bus.sample_en) overrun_q <= 1'b1;
      case (state)
        IDLE: if (bus.sample_en) begin
          freq_q <= bus.freq;
          // A new frequency restarts the rotation from phase 0.
          if (bus.freq != freq_q) begin
            x <= SEED;
            y <= '0;
          end
        end
        RX2: xr <= sat(rnd);
        RY2: yr <= sat(rnd);
        MY:  m  <= rnd[WL:0];
        NX:  x  <= sat(rnd);
        NY:  begin
          y        <= sat(rnd);
          sample_q <= sat(AW'(x) <<< 1);
        end
        default: ;
      endcase
    end
  end

  assign bus.sample    = sample_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;
endmodule
